// File: rtl/dac_ddr_formatter.sv
// Multi-channel DAC sample formatter: maps channel pairs onto DDR rise/fall words,
// with midscale muting, clock-forwarding warm-up and underflow hold/counting.
module dac_ddr_formatter #(
    parameter int unsigned DATA_WIDTH    = 14,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned OFFSET_BINARY = 0,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                enable_in,
    input  logic                                mute_in,
    input  logic                                clr_stats_in,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]        s_data,
    output logic [(NUM_CH/2)*DATA_WIDTH-1:0]    d_rise,
    output logic [(NUM_CH/2)*DATA_WIDTH-1:0]    d_fall,
    output logic                                dclk_en,
    output logic [1:0]                          state_out,
    output logic [15:0]                         underflow_cnt
);

    localparam int unsigned NUM_LANES = NUM_CH / 2;
    localparam int unsigned VEC_W     = NUM_CH * DATA_WIDTH;
    localparam int unsigned LANE_W    = NUM_LANES * DATA_WIDTH;
    localparam int unsigned WCNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    localparam logic [DATA_WIDTH-1:0] MSB       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MID       = (OFFSET_BINARY != 0) ? MSB : '0;
    localparam logic [LANE_W-1:0]     MID_LANES = {NUM_LANES{MID}};
    localparam logic [WCNT_W-1:0]     WARM_LAST = WCNT_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t              state;
    logic [WCNT_W-1:0]   warm_cnt;
    logic [VEC_W-1:0]    stage1;
    logic                stage1_mute;
    logic [LANE_W-1:0]   rise_c;
    logic [LANE_W-1:0]   fall_c;
    logic                xfer;

    assign s_ready   = (state == ST_RUN);
    assign state_out = 2'(state);
    assign xfer      = s_valid & s_ready;

    // Stage1 holds raw two's complement; zero formats to MID in either mode.
    always_comb begin
        rise_c = MID_LANES;
        fall_c = MID_LANES;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (!stage1_mute) begin
                rise_c[k*DATA_WIDTH +: DATA_WIDTH] =
                    stage1[(2*k)*DATA_WIDTH +: DATA_WIDTH] ^ ((OFFSET_BINARY != 0) ? MSB : '0);
                fall_c[k*DATA_WIDTH +: DATA_WIDTH] =
                    stage1[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] ^ ((OFFSET_BINARY != 0) ? MSB : '0);
            end
        end
    end

    // Sequencer and two-stage datapath; disable flushes both stages to midscale.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_OFF;
            warm_cnt    <= '0;
            dclk_en     <= 1'b0;
            stage1      <= '0;
            stage1_mute <= 1'b0;
            d_rise      <= MID_LANES;
            d_fall      <= MID_LANES;
        end else if (!enable_in) begin
            state       <= ST_OFF;
            warm_cnt    <= '0;
            dclk_en     <= 1'b0;
            stage1      <= '0;
            stage1_mute <= 1'b0;
            d_rise      <= MID_LANES;
            d_fall      <= MID_LANES;
        end else begin
            case (state)
                ST_OFF: begin
                    state    <= ST_WARMUP;
                    warm_cnt <= '0;
                    dclk_en  <= 1'b1;
                end
                ST_WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        warm_cnt <= warm_cnt + WCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        stage1      <= s_data;
                        stage1_mute <= mute_in;
                    end
                    d_rise <= rise_c;
                    d_fall <= fall_c;
                end
                default: begin
                    state   <= ST_OFF;
                    dclk_en <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of RUN cycles without a sample; clear has priority.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            underflow_cnt <= '0;
        end else if (clr_stats_in) begin
            underflow_cnt <= '0;
        end else if ((state == ST_RUN) && !s_valid && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule
